// File: rtl/lsa_boot_pkg.sv
// Shared types for the lsa boot/load controller and its bus mux.
// Address and word widths match lsa_mem.
package lsa_boot_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic [7:0] SYNC_LOAD_DEF = 8'hA5;
  localparam logic [7:0] SYNC_RUN_DEF  = 8'h5A;

  typedef enum logic [3:0] {
    ST_RUN    = 4'd0,
    ST_HALT   = 4'd1,
    ST_ADDR_H = 4'd2,
    ST_ADDR_L = 4'd3,
    ST_LEN_H  = 4'd4,
    ST_LEN_L  = 4'd5,
    ST_DATA_H = 4'd6,
    ST_DATA_L = 4'd7,
    ST_WRITE  = 4'd8
  } state_t;

  typedef struct packed {
    logic  fetch;
    logic  we;
    logic  oe;
    addr_t add;
    word_t data;
  } bus_t;

  function automatic logic is_loading(state_t s);
    return (s != ST_RUN) && (s != ST_HALT);
  endfunction

endpackage

// File: rtl/lsa_boot_ctl_if.sv
// Byte-stream handshake into the boot controller.
// A byte moves when rx_valid && rx_ready at a rising edge.
interface lsa_boot_ctl_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );

endinterface

// File: rtl/lsa_bus_mux.sv
// Combinational 2:1 memory bus selector.
// The loader side wins whenever loader_owns is high.
module lsa_bus_mux
  import lsa_boot_pkg::*;
(
  input  logic loader_owns,
  input  bus_t core_bus,
  input  bus_t loader_bus,
  output bus_t mem_bus
);

  assign mem_bus = loader_owns ? loader_bus : core_bus;

endmodule

// File: rtl/lsa_boot_ctl.sv
// Boot/load controller: parses a byte stream into memory writes
// while holding lsa_core in reset, then hands the bus back.
module lsa_boot_ctl
  import lsa_boot_pkg::*;
#(
  parameter bit         RUN_AT_RESET = 1'b0,
  parameter logic [7:0] SYNC_LOAD    = SYNC_LOAD_DEF,
  parameter logic [7:0] SYNC_RUN     = SYNC_RUN_DEF
) (
  input  logic          clock_in,
  input  logic          reset_in,
  lsa_boot_ctl_if.slave rx,
  input  logic          core_fetch,
  input  logic          core_we,
  input  logic          core_oe,
  input  addr_t         core_add,
  input  word_t         core_data,
  output logic          mem_fetch,
  output logic          mem_we,
  output logic          mem_oe,
  output addr_t         mem_add,
  output word_t         mem_in,
  output logic          core_reset_out,
  output logic          loading,
  output logic          cmd_err
);

  state_t     state;
  addr_t      addr;
  word_t      cnt;
  word_t      data;
  logic       take;
  logic [7:0] b;
  logic       loader_owns;

  bus_t core_bus;
  bus_t ld_bus;
  bus_t mem_bus;

  assign b           = rx.rx_data;
  assign rx.rx_ready = (state != ST_WRITE);
  assign take        = rx.rx_valid && rx.rx_ready;
  assign loading     = is_loading(state);
  assign loader_owns = (state != ST_RUN);

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state          <= RUN_AT_RESET ? ST_RUN : ST_HALT;
      core_reset_out <= 1'b0;
      cmd_err        <= 1'b0;
      addr           <= '0;
      cnt            <= '0;
      data           <= '0;
    end else begin
      // Core runs exactly while the FSM sits in RUN.
      core_reset_out <= (state == ST_RUN);
      case (state)
        ST_RUN: begin
          if (take && b == SYNC_LOAD) begin
            state          <= ST_ADDR_H;
            core_reset_out <= 1'b0;
            cmd_err        <= 1'b0;
          end
        end
        ST_HALT: begin
          if (take) begin
            if (b == SYNC_LOAD) begin
              state   <= ST_ADDR_H;
              cmd_err <= 1'b0;
            end else if (b == SYNC_RUN) begin
              state          <= ST_RUN;
              core_reset_out <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_ADDR_H: begin
          if (take) begin
            addr[15:8] <= b;
            state      <= ST_ADDR_L;
          end
        end
        ST_ADDR_L: begin
          if (take) begin
            addr[7:0] <= b;
            state     <= ST_LEN_H;
          end
        end
        ST_LEN_H: begin
          if (take) begin
            cnt[15:8] <= b;
            state     <= ST_LEN_L;
          end
        end
        ST_LEN_L: begin
          if (take) begin
            cnt[7:0] <= b;
            if ({cnt[15:8], b} == 16'd0)
              state <= ST_HALT;
            else
              state <= ST_DATA_H;
          end
        end
        ST_DATA_H: begin
          if (take) begin
            data[15:8] <= b;
            state      <= ST_DATA_L;
          end
        end
        ST_DATA_L: begin
          if (take) begin
            data[7:0] <= b;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          addr <= addr + 16'd1;
          cnt  <= cnt - 16'd1;
          if (cnt == 16'd1)
            state <= ST_HALT;
          else
            state <= ST_DATA_H;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  assign core_bus = '{
    fetch: core_fetch,
    we:    core_we,
    oe:    core_oe,
    add:   core_add,
    data:  core_data
  };

  assign ld_bus = '{
    fetch: 1'b0,
    we:    (state == ST_WRITE),
    oe:    1'b0,
    add:   addr,
    data:  data
  };

  lsa_bus_mux u_mux (
    .loader_owns (loader_owns),
    .core_bus    (core_bus),
    .loader_bus  (ld_bus),
    .mem_bus     (mem_bus)
  );

  assign mem_fetch = mem_bus.fetch;
  assign mem_we    = mem_bus.we;
  assign mem_oe    = mem_bus.oe;
  assign mem_add   = mem_bus.add;
  assign mem_in    = mem_bus.data;

endmodule

// File: tb/tb_lsa_boot_ctl.sv
// Randomized bench for lsa_boot_ctl against a stream-level
// model of the load protocol.
module tb_lsa_boot_ctl;

  logic        clk;
  logic        reset_in;
  logic        core_fetch;
  logic        core_we;
  logic        core_oe;
  logic [15:0] core_add;
  logic [15:0] core_data;
  logic        mem_fetch;
  logic        mem_we;
  logic        mem_oe;
  logic [15:0] mem_add;
  logic [15:0] mem_in;
  logic        core_reset_out;
  logic        loading;
  logic        cmd_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] obs[$];
  logic        obs_rdy[$];
  logic [31:0] exp_q[$];

  lsa_boot_ctl_if rx ();

  lsa_boot_ctl dut (
    .clock_in       (clk),
    .reset_in       (reset_in),
    .rx             (rx),
    .core_fetch     (core_fetch),
    .core_we        (core_we),
    .core_oe        (core_oe),
    .core_add       (core_add),
    .core_data      (core_data),
    .mem_fetch      (mem_fetch),
    .mem_we         (mem_we),
    .mem_oe         (mem_oe),
    .mem_add        (mem_add),
    .mem_in         (mem_in),
    .core_reset_out (core_reset_out),
    .loading        (loading),
    .cmd_err        (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture loader writes as they commit.
  always @(posedge clk) begin
    if (reset_in && loading && mem_we) begin
      obs.push_back({mem_add, mem_in});
      obs_rdy.push_back(rx.rx_ready);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a load is A5, addr(2), len(2), len words (2 each).
  function automatic void model(input logic [7:0] s[$]);
    int          i;
    logic [15:0] a;
    logic [15:0] n;
    i = 0;
    while (i < s.size()) begin
      if (s[i] == 8'hA5 && i + 4 < s.size()) begin
        a = {s[i+1], s[i+2]};
        n = {s[i+3], s[i+4]};
        i = i + 5;
        for (int k = 0; k < int'(n); k++) begin
          exp_q.push_back({a, s[i], s[i+1]});
          a = a + 16'd1;
          i = i + 2;
        end
      end else begin
        i = i + 1;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] v, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx.rx_valid = 1'b1;
    rx.rx_data  = v;
    n = 0;
    while (!rx.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h never accepted", v);
    end
    @(negedge clk);
    rx.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_in   = 1'b0;
    core_fetch = 1'b1;
    core_oe    = 1'b1;
    core_we    = 1'b1;
    core_add   = 16'hBEEF;
    core_data  = 16'h1111;
    repeat (3) @(negedge clk);
    total++;
    if (core_reset_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_core_in_reset: got %b want 0", core_reset_out);
    end
    reset_in = 1'b1;
    @(negedge clk);
    total++;
    if (core_reset_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_core_after: got %b want 0", core_reset_out);
    end
    total++;
    if (rx.rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: got %b want 1", rx.rx_ready);
    end
    total++;
    if ({mem_fetch, mem_we, mem_oe} !== 3'b000) begin
      bad++;
      $display("FAIL rst_strobes: got %b want 000",
               {mem_fetch, mem_we, mem_oe});
    end
    total++;
    if ({loading, cmd_err} !== 2'b00) begin
      bad++;
      $display("FAIL rst_flags: got %b want 00", {loading, cmd_err});
    end
    total++;
    if (mem_add !== 16'h0000) begin
      bad++;
      $display("FAIL rst_addr: got %h want 0000", mem_add);
    end
    core_fetch = 1'b0;
    core_oe    = 1'b0;
    core_we    = 1'b0;
  endtask

  task automatic test_single_load();
    logic [7:0]  s[$];
    logic [31:0] e[$];
    s = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02,
          8'h12, 8'h34, 8'hAB, 8'hCD};
    e = '{32'h0010_1234, 32'h0011_ABCD};
    obs.delete();
    obs_rdy.delete();
    foreach (s[i]) send_byte(s[i], 0);
    repeat (4) @(negedge clk);
    total++;
    if (obs.size() !== 2) begin
      bad++;
      $display("FAIL single_count: got %0d want 2", obs.size());
    end
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== e[i]) begin
        bad++;
        $display("FAIL single_write%0d: got %h want %h", i, obs[i], e[i]);
      end
      total++;
      if (obs_rdy[i] !== 1'b0) begin
        bad++;
        $display("FAIL single_ready%0d: got %b want 0", i, obs_rdy[i]);
      end
    end
    total++;
    if ({loading, core_reset_out} !== 2'b00) begin
      bad++;
      $display("FAIL single_halt: got %b want 00",
               {loading, core_reset_out});
    end
    core_add = 16'h0123;
    send_byte(8'h5A, 0);
    total++;
    if (core_reset_out !== 1'b1) begin
      bad++;
      $display("FAIL run_release: got %b want 1", core_reset_out);
    end
    total++;
    if (mem_add !== 16'h0123) begin
      bad++;
      $display("FAIL run_passthru: got %h want 0123", mem_add);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  s[$];
    logic [31:0] e[$];
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    s = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02,
          w0[15:8], w0[7:0], w1[15:8], w1[7:0]};
    e = '{{16'hFFFF, w0}, {16'h0000, w1}};
    obs.delete();
    obs_rdy.delete();
    foreach (s[i]) send_byte(s[i], 0);
    repeat (4) @(negedge clk);
    total++;
    if (obs.size() !== 2) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 2", obs.size());
    end
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== e[i]) begin
        bad++;
        $display("FAIL wrap_write%0d: got %h want %h", i, obs[i], e[i]);
      end
    end
    obs.delete();
    obs_rdy.delete();
    s = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    foreach (s[i]) send_byte(s[i], 0);
    repeat (4) @(negedge clk);
    total++;
    if (obs.size() !== 0) begin
      bad++;
      $display("FAIL zero_len_writes: got %0d want 0", obs.size());
    end
    total++;
    if ({loading, core_reset_out, rx.rx_ready} !== 3'b001) begin
      bad++;
      $display("FAIL zero_len_halt: got %b want 001",
               {loading, core_reset_out, rx.rx_ready});
    end
  endtask

  task automatic test_load_from_run();
    send_byte(8'h5A, 0);
    core_we   = 1'b1;
    core_add  = 16'h0200;
    core_data = 16'($urandom);
    @(negedge clk);
    total++;
    if ({mem_we, mem_add} !== {1'b1, 16'h0200}) begin
      bad++;
      $display("FAIL run_core_we: got %b/%h want 1/0200", mem_we, mem_add);
    end
    send_byte(8'hA5, 0);
    total++;
    if (core_reset_out !== 1'b0) begin
      bad++;
      $display("FAIL sync_load_reset: got %b want 0", core_reset_out);
    end
    total++;
    if ({mem_we, loading} !== 2'b01) begin
      bad++;
      $display("FAIL sync_load_bus: got %b want 01", {mem_we, loading});
    end
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    core_we = 1'b0;
    total++;
    if (loading !== 1'b0) begin
      bad++;
      $display("FAIL run_load_end: got %b want 0", loading);
    end
  endtask

  task automatic test_error();
    logic [7:0] s[$];
    send_byte(8'h3C, 0);
    total++;
    if (cmd_err !== 1'b1) begin
      bad++;
      $display("FAIL err_set: got %b want 1", cmd_err);
    end
    send_byte(8'hA5, 0);
    total++;
    if (cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %b want 0", cmd_err);
    end
    s = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h77};
    foreach (s[i]) send_byte(s[i], 0);
    obs.delete();
    obs_rdy.delete();
    reset_in = 1'b0;
    @(negedge clk);
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs.size() !== 0) begin
      bad++;
      $display("FAIL abort_writes: got %0d want 0", obs.size());
    end
    total++;
    if ({loading, core_reset_out} !== 2'b00) begin
      bad++;
      $display("FAIL abort_state: got %b want 00",
               {loading, core_reset_out});
    end
    send_byte(8'h5A, 0);
    total++;
    if (core_reset_out !== 1'b1) begin
      bad++;
      $display("FAIL abort_halt: got %b want 1", core_reset_out);
    end
  endtask

  task automatic test_throttled();
    logic [7:0]  s[$];
    logic [15:0] a;
    logic [15:0] w;
    int          n;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        s = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02,
              8'h12, 8'h34, 8'hAB, 8'hCD};
      end else begin
        a = (r == 3) ? 16'hFFFE : 16'($urandom);
        n = $urandom_range(1, 4);
        s = '{8'hA5, a[15:8], a[7:0], 8'h00, 8'(n)};
        for (int k = 0; k < n; k++) begin
          w = 16'($urandom);
          s.push_back(w[15:8]);
          s.push_back(w[7:0]);
        end
      end
      exp_q.delete();
      model(s);
      obs.delete();
      obs_rdy.delete();
      foreach (s[i]) send_byte(s[i], $urandom_range(0, 3));
      repeat (4) @(negedge clk);
      total++;
      if (obs.size() !== exp_q.size()) begin
        bad++;
        $display("FAIL thr%0d_count: got %0d want %0d",
                 r, obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        total++;
        if (obs[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL thr%0d_write%0d: got %h want %h",
                   r, i, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    reset_in    = 1'b0;
    core_fetch  = 1'b0;
    core_we     = 1'b0;
    core_oe     = 1'b0;
    core_add    = 16'h0000;
    core_data   = 16'h0000;
    @(negedge clk);
    test_reset();
    test_single_load();
    test_wrap();
    test_load_from_run();
    test_error();
    test_throttled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
